dshot_receiver: RTL and testbench
=================================

# dshot_receiver

Decodes a DShot serial line back into an 11-bit throttle value and a 1-bit flag. It is the receive-side counterpart of the drone DShot transmit path and is used for loopback verification of the transmitter and for bench ESC emulation. The block oversamples the line on `Clock` and classifies each bit by its high-time. It assembles 16-bit frames MSB-first, verifies the 4-bit check nibble, and reports valid frames, checksum failures and framing faults as single-cycle pulses.

## Interface
- `THRESH`, 13: high-time in cycles at or above which a bit decodes as 1; below it, the bit decodes as 0.
- `MIN_HIGH`, 3: high pulses shorter than this are glitches.
- `MAX_HIGH`, 22: a high-time exceeding this is a stuck-high fault.
- `GAP_CYCLES`, 32: low-time that ends a frame in progress as truncated; must exceed the longest inter-bit low.
- `Clock`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  reset, asynchronous, active-high; clock `Clock`.
- `dIn`  in  1  raw DShot line, asynchronous to `Clock`.
- `throttle`  out  11  throttle of the last good frame (packet bits 15:5); reset 0.
- `flag`  out  1  flag bit of the last good frame (packet bit 4); reset 0.
- `valid`  out  1  one-cycle pulse when `throttle`/`flag` update with a good frame; reset 0.
- `crcError`  out  1  one-cycle pulse when a complete frame fails its checksum; reset 0.
- `frameError`  out  1  one-cycle pulse on a glitch, stuck-high or truncated frame; reset 0.
- `busy`  out  1  high while a frame is in progress (bit count 1..15, or in HIGH); reset 0.

## Operation
- Frame format: 16 bits, MSB first. `d = packet[15:4]`. Check rule: `packet[3:0] == d[3:0] ^ d[7:4] ^ d[11:8]`.
- Synchronizer: `dIn` passes through two flops to give `s`. A third flop holds `s_prev` for edge detection (rise: `s & !s_prev`; fall: `!s & s_prev`).
- Counters:
  - `hcnt`: 8-bit high-time counter, saturating at 255.
  - `lcnt`: 8-bit low-time counter, saturating.
  - `bitcnt`: 5-bit bit counter, 0..16.
  - Shift register: 16 bits.
- FSM states:
  - IDLE: `bitcnt` = 0. On rise, go to HIGH with `hcnt` = 1.
  - HIGH: increment `hcnt` each cycle while `s` = 1.
    - If `hcnt` exceeds `MAX_HIGH`: pulse `frameError` and go to WAIT_LOW.
    - On fall with `hcnt` < `MIN_HIGH`: if `bitcnt` = 0, return silently to IDLE; otherwise pulse `frameError` and go to IDLE.
    - On fall otherwise: shift in `(hcnt >= THRESH)`, increment `bitcnt`, clear `lcnt`. If the new `bitcnt` = 16, go to CHECK; else go to LOW.
  - LOW: increment `lcnt` each cycle while `s` = 0.
    - On rise: go to HIGH with `hcnt` = 1.
    - If `lcnt` reaches `GAP_CYCLES`: pulse `frameError`, clear `bitcnt`, go to IDLE.
  - CHECK (one cycle):
    - Checksum passes: load `throttle` and `flag` and pulse `valid`.
    - Checksum fails: pulse `crcError`; `throttle`/`flag` hold.
    - Either way, clear `bitcnt` and go to IDLE.
  - WAIT_LOW: stay until `s` = 0, then go to IDLE. No pulses are issued here.
- At most one of `valid`/`crcError`/`frameError` is high in any cycle.
- `throttle`/`flag` change only in the cycle `valid` is high.
- Back-to-back frames: a rise seen in IDLE immediately after CHECK starts the next frame. No minimum gap is required.
- Reset mid-frame: all state returns to IDLE, outputs go to 0, and no pulse is emitted for the abandoned frame.

## Timing
- `dIn` edge to FSM edge detection: 2 Clock cycles (synchronizer).
- Last-bit fall to result: if `dIn` falls at rising edge k, `s` falls at edge k+2. The FSM enters CHECK at edge k+3. `valid`/`crcError` and the new `throttle` are visible from edge k+4 for exactly one cycle. The fixed latency is therefore 4 cycles from the sampled fall.
- High-time measurement: `hcnt` equals the number of cycles `s` was high. A clean N-cycle `dIn` pulse measures as N.
- `frameError` for a truncated frame is asserted `GAP_CYCLES` + 1 cycles after the last fall of `s`.
- Nominal stimulus (defaults): bit period 24 cycles; a 1 is 18 high + 6 low; a 0 is 9 high + 15 low.

## Test plan
- Reset is held for 3 cycles, then released with `dIn` = 0. Required: all outputs 0 and `busy` = 0 for 50 cycles.
- Good frame: drive packet `0x7D1B` (throttle 1000, flag 1) at nominal timing. Required: `valid` pulses once, exactly 4 cycles after the 16th fall; `throttle` = 1000, `flag` = 1; no error pulses. Then drive `0x0000` back-to-back. Required: second `valid`, `throttle` = 0, `flag` = 0.
- Checksum error: after the good frame, drive `0x7D1A`. Required: one `crcError` pulse, no `valid`; `throttle` stays 1000.
- Truncated frame: drive 10 bits, then hold `dIn` low for 40 cycles. Required: `frameError` pulses once, 33 cycles after the 10th fall; `busy` drops. A following `0x7D1B` decodes normally.
- Glitch and stuck-high:
  - A 2-cycle high pulse in IDLE: no pulse at all.
  - A 2-cycle high pulse as bit 5: `frameError`.
  - `dIn` high for 30 cycles: one `frameError` when `hcnt` reaches 23, no further pulses until `dIn` goes low. The next good frame then decodes.
- Reset mid-frame: assert `Reset` after 8 bits of `0x7D1B`. Required: outputs 0, no pulse; a complete frame driven after release decodes to 1000.

Source files
------------

// File: rtl/dshot_receiver.sv
// DShot line decoder: oversamples dIn, classifies bits by high-time, assembles
// 16-bit MSB-first frames and reports good frames, checksum and framing faults.
module dshot_receiver #(
  parameter int THRESH     = 13,
  parameter int MIN_HIGH   = 3,
  parameter int MAX_HIGH   = 22,
  parameter int GAP_CYCLES = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        dIn,
  output logic [10:0] throttle,
  output logic        flag,
  output logic        valid,
  output logic        crcError,
  output logic        frameError,
  output logic        busy
);

  localparam logic [7:0] TH_C   = 8'(THRESH);
  localparam logic [7:0] MINH_C = 8'(MIN_HIGH);
  localparam logic [7:0] MAXH_C = 8'(MAX_HIGH);
  localparam logic [7:0] GAP_C  = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, CHECK, WAIT_LOW} state_t;

  state_t      state, state_n;
  logic        s1, s, s_prev;
  logic        rise, fall;
  logic [7:0]  hcnt, hcnt_n, lcnt, lcnt_n, hinc, linc;
  logic [4:0]  bitcnt, bitcnt_n;
  logic [15:0] sreg, sreg_n;
  logic [10:0] throttle_n;
  logic        flag_n, valid_n, crc_n, ferr_n;
  logic [3:0]  chk;

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;
  assign hinc = (hcnt == 8'hff) ? hcnt : hcnt + 8'd1;
  assign linc = (lcnt == 8'hff) ? lcnt : lcnt + 8'd1;
  assign chk  = sreg[7:4] ^ sreg[11:8] ^ sreg[15:12];
  assign busy = (state == HIGH) || ((bitcnt != 5'd0) && (bitcnt != 5'd16));

  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    lcnt_n     = lcnt;
    bitcnt_n   = bitcnt;
    sreg_n     = sreg;
    throttle_n = throttle;
    flag_n     = flag;
    valid_n    = 1'b0;
    crc_n      = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          hcnt_n  = 8'd1;
        end
      end
      HIGH: begin
        if (hcnt > MAXH_C) begin
          ferr_n   = 1'b1;
          bitcnt_n = 5'd0;
          state_n  = WAIT_LOW;
        end else if (fall) begin
          if (hcnt < MINH_C) begin
            // a lone short pulse before any bit is line noise, not a fault
            ferr_n   = (bitcnt != 5'd0);
            bitcnt_n = 5'd0;
            state_n  = IDLE;
          end else begin
            sreg_n   = {sreg[14:0], (hcnt >= TH_C)};
            bitcnt_n = bitcnt + 5'd1;
            lcnt_n   = 8'd0;
            state_n  = (bitcnt == 5'd15) ? CHECK : LOW;
          end
        end else begin
          hcnt_n = hinc;
        end
      end
      LOW: begin
        if (rise) begin
          state_n = HIGH;
          hcnt_n  = 8'd1;
        end else begin
          lcnt_n = linc;
          if (linc == GAP_C) begin
            ferr_n   = 1'b1;
            bitcnt_n = 5'd0;
            state_n  = IDLE;
          end
        end
      end
      CHECK: begin
        if (sreg[3:0] == chk) begin
          throttle_n = sreg[15:5];
          flag_n     = sreg[4];
          valid_n    = 1'b1;
        end else begin
          crc_n = 1'b1;
        end
        bitcnt_n = 5'd0;
        state_n  = IDLE;
      end
      WAIT_LOW: begin
        if (!s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      s_prev     <= 1'b0;
      state      <= IDLE;
      hcnt       <= 8'd0;
      lcnt       <= 8'd0;
      bitcnt     <= 5'd0;
      sreg       <= 16'd0;
      throttle   <= 11'd0;
      flag       <= 1'b0;
      valid      <= 1'b0;
      crcError   <= 1'b0;
      frameError <= 1'b0;
    end else begin
      s1         <= dIn;
      s          <= s1;
      s_prev     <= s;
      state      <= state_n;
      hcnt       <= hcnt_n;
      lcnt       <= lcnt_n;
      bitcnt     <= bitcnt_n;
      sreg       <= sreg_n;
      throttle   <= throttle_n;
      flag       <= flag_n;
      valid      <= valid_n;
      crcError   <= crc_n;
      frameError <= ferr_n;
    end
  end

endmodule

// File: tb/tb_dshot_receiver.sv
// Directed bench for dshot_receiver: nominal frames, checksum, truncation,
// glitch, stuck-high and reset-mid-frame scenarios with hand-computed timing.
module tb_dshot_receiver;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        dIn = 1'b0;
  logic [10:0] throttle;
  logic        flag, valid, crcError, frameError, busy;

  dshot_receiver dut (
    .Clock(Clock), .Reset(Reset), .dIn(dIn), .throttle(throttle), .flag(flag),
    .valid(valid), .crcError(crcError), .frameError(frameError), .busy(busy)
  );

  always #5 Clock = ~Clock;

  int checks = 0, failures = 0;
  int cyc = 0, last_fall = 0;
  int n_valid = 0, n_crc = 0, n_ferr = 0, n_multi = 0, n_thrbad = 0;
  int crc_cyc = 0, ferr_cyc = 0;
  logic [11:0] vq[$];
  int vc[$];
  logic [11:0] prev_out = 12'd0;

  always @(posedge Clock) cyc <= cyc + 1;

  // pulse / output-change monitor, sampled mid-cycle
  always @(negedge Clock) begin
    if (valid === 1'b1) begin n_valid++; vq.push_back({flag, throttle}); vc.push_back(cyc); end
    if (crcError === 1'b1) begin n_crc++; crc_cyc = cyc; end
    if (frameError === 1'b1) begin n_ferr++; ferr_cyc = cyc; end
    if (32'(valid) + 32'(crcError) + 32'(frameError) > 1) n_multi++;
    if (!Reset && valid !== 1'b1 && {flag, throttle} !== prev_out) n_thrbad++;
    prev_out = {flag, throttle};
  end

  task automatic pulse(input int hi, input int lo);
    @(posedge Clock); #1; dIn = 1'b1;
    repeat (hi) @(posedge Clock);
    #1; dIn = 1'b0; last_fall = cyc;
    repeat (lo - 1) @(posedge Clock);
  endtask

  task automatic send_frame(input logic [15:0] pkt, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      if (pkt[i]) pulse(18, 6);
      else pulse(9, 15);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    int bad = 0;
    Reset = 1'b1; dIn = 1'b0;
    repeat (3) @(posedge Clock);
    #1; Reset = 1'b0;
    repeat (50) begin
      @(negedge Clock);
      if ({throttle, flag, valid, crcError, frameError, busy} !== 16'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL reset_outputs bad_cycles=%0d want 0", bad); end
    checks++; if (n_valid + n_crc + n_ferr !== 0) begin failures++; $display("FAIL reset_pulses got %0d want 0", n_valid + n_crc + n_ferr); end
  endtask

  task automatic test_back_to_back;
    int f1, f2, e0;
    vq.delete(); vc.delete();
    e0 = n_crc + n_ferr;
    send_frame(16'h7D1B, 16); f1 = last_fall;
    send_frame(16'h0000, 16); f2 = last_fall;
    idle(10);
    checks++; if (vq.size() !== 2) begin failures++; $display("FAIL b2b_valid_count got %0d want 2", vq.size()); end
    checks++; if (vq[0] !== {1'b1, 11'd1000}) begin failures++; $display("FAIL good_frame_data got %h want %h", vq[0], {1'b1, 11'd1000}); end
    checks++; if (vc[0] - f1 !== 4) begin failures++; $display("FAIL good_frame_latency got %0d want 4", vc[0] - f1); end
    checks++; if (vq[1] !== 12'd0) begin failures++; $display("FAIL b2b_zero_data got %h want 000", vq[1]); end
    checks++; if (vc[1] - f2 !== 4) begin failures++; $display("FAIL b2b_latency got %0d want 4", vc[1] - f2); end
    checks++; if (n_crc + n_ferr !== e0) begin failures++; $display("FAIL b2b_errors got %0d want %0d", n_crc + n_ferr, e0); end
  endtask

  task automatic test_truncated;
    int f, e0, v0;
    e0 = n_ferr; v0 = n_valid;
    send_frame(16'h7D1B, 10); f = last_fall;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL trunc_busy_mid got %b want 1", busy); end
    idle(40);
    checks++; if (n_ferr - e0 !== 1) begin failures++; $display("FAIL trunc_ferr_count got %0d want 1", n_ferr - e0); end
    // two synchronizer cycles plus GAP_CYCLES+1 after the fall of s
    checks++; if (ferr_cyc - f !== 35) begin failures++; $display("FAIL trunc_ferr_time got %0d want 35", ferr_cyc - f); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL trunc_busy_end got %b want 0", busy); end
    checks++; if (n_valid !== v0) begin failures++; $display("FAIL trunc_no_valid got %0d want %0d", n_valid, v0); end
    send_frame(16'h7D1B, 16); idle(10);
    checks++; if (n_valid - v0 !== 1 || throttle !== 11'd1000) begin failures++; $display("FAIL trunc_recover got valid=%0d thr=%0d want 1 1000", n_valid - v0, throttle); end
  endtask

  task automatic test_crc_error;
    int f, v0, c0;
    send_frame(16'h7D1B, 16); idle(10);
    v0 = n_valid; c0 = n_crc;
    send_frame(16'h7D1A, 16); f = last_fall; idle(10);
    checks++; if (n_crc - c0 !== 1) begin failures++; $display("FAIL crc_count got %0d want 1", n_crc - c0); end
    checks++; if (crc_cyc - f !== 4) begin failures++; $display("FAIL crc_latency got %0d want 4", crc_cyc - f); end
    checks++; if (n_valid !== v0) begin failures++; $display("FAIL crc_no_valid got %0d want %0d", n_valid, v0); end
    checks++; if ({flag, throttle} !== {1'b1, 11'd1000}) begin failures++; $display("FAIL crc_hold got thr=%0d flag=%b want 1000 1", throttle, flag); end
  endtask

  task automatic test_glitch;
    int f, t0;
    t0 = n_valid + n_crc + n_ferr;
    pulse(2, 40);
    checks++; if (n_valid + n_crc + n_ferr !== t0) begin failures++; $display("FAIL glitch_idle_pulses got %0d want %0d", n_valid + n_crc + n_ferr, t0); end
    t0 = n_ferr;
    send_frame(16'h7D1B, 4);
    pulse(2, 40); f = last_fall;
    checks++; if (n_ferr - t0 !== 1) begin failures++; $display("FAIL glitch_bit5_count got %0d want 1", n_ferr - t0); end
    checks++; if (ferr_cyc - f !== 3) begin failures++; $display("FAIL glitch_bit5_time got %0d want 3", ferr_cyc - f); end
  endtask

  task automatic test_stuck_high;
    int r, e0, v0;
    e0 = n_ferr; v0 = n_valid + n_crc;
    @(posedge Clock); #1; dIn = 1'b1; r = cyc;
    repeat (30) @(posedge Clock);
    #1; dIn = 1'b0;
    idle(40);
    checks++; if (n_ferr - e0 !== 1) begin failures++; $display("FAIL stuck_count got %0d want 1", n_ferr - e0); end
    // hcnt reaches 23 at rise+25, pulse registered one edge later
    checks++; if (ferr_cyc - r !== 26) begin failures++; $display("FAIL stuck_time got %0d want 26", ferr_cyc - r); end
    send_frame(16'h7D1B, 16); idle(10);
    checks++; if (n_valid + n_crc - v0 !== 1 || throttle !== 11'd1000) begin failures++; $display("FAIL stuck_recover got n=%0d thr=%0d want 1 1000", n_valid + n_crc - v0, throttle); end
  endtask

  task automatic test_reset_mid_frame;
    int t0, v0;
    send_frame(16'h7D1B, 8);
    t0 = n_valid + n_crc + n_ferr;
    @(posedge Clock); #1; Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1; Reset = 1'b0;
    @(negedge Clock);
    checks++; if ({throttle, flag, busy} !== 13'd0) begin failures++; $display("FAIL midreset_outputs got thr=%0d flag=%b busy=%b want 0", throttle, flag, busy); end
    idle(40);
    checks++; if (n_valid + n_crc + n_ferr !== t0) begin failures++; $display("FAIL midreset_pulses got %0d want %0d", n_valid + n_crc + n_ferr, t0); end
    v0 = n_valid;
    send_frame(16'h7D1B, 16); idle(10);
    checks++; if (n_valid - v0 !== 1 || throttle !== 11'd1000 || flag !== 1'b1) begin failures++; $display("FAIL midreset_recover got n=%0d thr=%0d flag=%b want 1 1000 1", n_valid - v0, throttle, flag); end
  endtask

  task automatic test_invariants;
    checks++; if (n_multi !== 0) begin failures++; $display("FAIL pulse_exclusive got %0d want 0", n_multi); end
    checks++; if (n_thrbad !== 0) begin failures++; $display("FAIL output_change_without_valid got %0d want 0", n_thrbad); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_truncated;
    test_crc_error;
    test_glitch;
    test_stuck_high;
    test_reset_mid_frame;
    test_invariants;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
